// File: rtl/outreg_pkg.sv
// Shared types and constants for the buffered output port.
// The read FSM state type is also exported on the top's debug port.
package outreg_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SHOW = 1'b1
   } state_t;

   localparam logic MODE_DIRECT = 1'b0;
   localparam logic MODE_FIFO   = 1'b1;
   localparam int   DROP_CNT_W  = 8;

   function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/outreg_fifo.sv
// Synchronous DATA_W x DEPTH FIFO with registered full/empty/count.
// rdata is the current head entry; flush empties the FIFO like clr does.
module outreg_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4,
   parameter int CNT_W  = $clog2(DEPTH+1)
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              flush,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              full,
   output logic              empty,
   output logic [CNT_W-1:0]  count
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  cnt_nxt;
   logic              do_push;
   logic              do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   always_comb begin
      cnt_nxt = count;
      case ({do_push, do_pop})
         2'b10:   cnt_nxt = count + CNT_W'(1);
         2'b01:   cnt_nxt = count - CNT_W'(1);
         default: cnt_nxt = count;
      endcase
   end

   // Storage has no reset; only pointers and flags do.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (!clr || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= cnt_nxt;
         full  <= (cnt_nxt == CNT_W'(DEPTH));
         empty <= (cnt_nxt == '0);
      end
   end

endmodule

// File: rtl/out_port_buffered.sv
// Bus-to-display output port: DIRECT latch or FIFO-buffered valid/ack mode.
// Optional OUTREG_DROP_CNT_EN adds a saturating drop_cnt output.
//
// Handshake: display/disp_valid are offered by this block; a value is consumed
// at a posedge where disp_valid=1 and disp_ack=1. disp_ack with disp_valid=0 is ignored.
module out_port_buffered
   import outreg_pkg::*;
#(
   parameter  int DATA_W = 8,
   parameter  int DEPTH  = 4,
   localparam int CNT_W  = $clog2(DEPTH+1)
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              mode,
   input  logic [DATA_W-1:0] busin,
   input  logic              wa,
   output logic [DATA_W-1:0] display,
   output logic              disp_valid,
   input  logic              disp_ack,
   output logic              full,
   output logic              empty,
   output logic [CNT_W-1:0]  count,
   output logic              overflow,
   output state_t            fsm_state
`ifdef OUTREG_DROP_CNT_EN
   ,
   output logic [DROP_CNT_W-1:0] drop_cnt
`endif
);

   logic              mode_q;
   logic              mode_chg;
   logic              fifo_act;
   logic              push;
   logic              pop;
   logic              drop;
   logic [DATA_W-1:0] head;
   state_t            state;

   assign mode_chg  = (mode != mode_q);
   assign fifo_act  = !mode_chg && (mode_q == MODE_FIFO);
   // full/empty are the pre-edge registered flags, so a write into a full FIFO drops even with a pop.
   assign push      = fifo_act && wa && !full;
   assign drop      = fifo_act && wa && full;
   assign pop       = fifo_act && !empty && ((state == IDLE) || disp_ack);
   assign fsm_state = state;

   outreg_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .CNT_W  (CNT_W)
   ) u_fifo (
      .clk   (clk),
      .clr   (clr),
      .flush (mode_chg),
      .push  (push),
      .pop   (pop),
      .wdata (busin),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   always_ff @(posedge clk) begin
      if (!clr) begin
         mode_q     <= mode;
         state      <= IDLE;
         display    <= '0;
         disp_valid <= 1'b0;
      end else begin
         mode_q <= mode;
         if (mode_chg) begin
            state      <= IDLE;
            disp_valid <= 1'b0;
         end else if (mode_q == MODE_DIRECT) begin
            state <= IDLE;
            if (wa) begin
               display    <= busin;
               disp_valid <= 1'b1;
            end else if (disp_ack) begin
               disp_valid <= 1'b0;
            end
         end else begin
            case (state)
               IDLE: begin
                  if (!empty) begin
                     display    <= head;
                     disp_valid <= 1'b1;
                     state      <= SHOW;
                  end
               end
               SHOW: begin
                  if (disp_ack) begin
                     if (!empty) begin
                        display <= head;
                     end else begin
                        disp_valid <= 1'b0;
                        state      <= IDLE;
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!clr)      overflow <= 1'b0;
      else if (drop) overflow <= 1'b1;
   end

`ifdef OUTREG_DROP_CNT_EN
   always_ff @(posedge clk) begin
      if (!clr)      drop_cnt <= '0;
      else if (drop) drop_cnt <= sat_inc(drop_cnt);
   end
`endif

endmodule

// File: doc/out_port_buffered.md
Name: out_port_buffered

Overview:
Parametrised successor to the single-byte output register. Captures bus writes into a DEPTH-entry FIFO and presents them one at a time on the display port under a valid/ack handshake. A DIRECT mode keeps the legacy latch behaviour: write strobe, then the display updates the next edge. Sits between the system bus and the display/peripheral side of the computer.

Parameters:
DATA_W, 8, bus and display width in bits.
DEPTH, 4, FIFO entries; power of two, >= 2.
CNT_W, $clog2(DEPTH+1), width of the occupancy count (derived, not overridden).

Ports:
clk  in  1  single clock, all logic on posedge.
clr  in  1  synchronous active-low reset; sampled at posedge, 0 = reset.
mode  in  1  0 = DIRECT latch, 1 = FIFO buffered.
busin  in  DATA_W  bus data.
wa  in  1  write strobe, level-sampled each posedge.
display  out  DATA_W  currently shown value.
disp_valid  out  1  display holds an unacknowledged value.
disp_ack  in  1  consumer accepts the current display value.
full  out  1  FIFO occupancy == DEPTH.
empty  out  1  FIFO occupancy == 0.
count  out  CNT_W  FIFO occupancy.
overflow  out  1  sticky: a write was dropped while full.

Behaviour:
- Reset (clr==0 at posedge): display=0, disp_valid=0, full=0, empty=1, count=0, overflow=0, rd/wr pointers=0, FSM=IDLE. Reset wins over every other input, mid-operation included.
- All outputs are registered. No combinational path from inputs to outputs.
- DIRECT (mode=0):
  - wa=1 at edge T: display<=busin, disp_valid<=1 at T.
  - disp_ack with disp_valid=1 clears disp_valid. display holds its value.
  - wa and disp_ack at the same edge: the write wins, disp_valid stays 1.
  - FIFO stays empty.
- FIFO (mode=1), write side:
  - wa=1 and full=0: push busin at wr_ptr. Pointer wraps modulo DEPTH.
  - wa=1 and full=1: the write is dropped and overflow<=1. The flag clears only on reset.
  - full is the registered value before any same-edge pop, so a write to a full FIFO is dropped even if a pop occurs at the same edge.
- FIFO mode, read FSM:
  - IDLE: if empty=0, pop the head into display, set disp_valid=1, go to SHOW. Else stay in IDLE.
  - SHOW: disp_ack=1 and empty=0: pop the next entry at the same edge (back-to-back, no bubble), stay in SHOW. disp_ack=1 and empty=1: disp_valid<=0, go to IDLE. disp_ack=0: hold.
- Latency: a write accepted at edge T into an empty FIFO with the FSM in IDLE appears on display with disp_valid=1 at edge T+1.
- Push and pop at the same edge: count is unchanged, full and empty are unchanged.
- count, full and empty update at the same edge as the push or pop.
- disp_ack while disp_valid=0 is ignored.
- Mode change (mode differs from its registered copy at a posedge):
  - flush the FIFO (pointers and count to 0),
  - set disp_valid=0 and FSM=IDLE,
  - keep display at its value,
  - ignore wa at that edge,
  - leave overflow unchanged.

Optional Feature:
OUTREG_DROP_CNT_EN: when defined, adds port drop_cnt (out, 8 bits). It is a saturating count of dropped writes: reset to 0, holds at 255. When undefined, the port and counter are absent and only the sticky overflow flag reports drops.

Decomposition:
- Package outreg_pkg holds:
  - the FSM state enum (IDLE, SHOW),
  - the mode constants MODE_DIRECT=1'b0 and MODE_FIFO=1'b1,
  - DROP_CNT_W=8.
- One sub-module, outreg_fifo. It is a synchronous DATA_W x DEPTH FIFO with push, pop, full, empty and count, and an active-low synchronous clr.
- The top contains the mode register, the read FSM, the display register and the overflow/drop logic.

Test Plan:
1. DIRECT: clr low 2 cycles then high; busin=0x22, wa=1 for 1 edge -> display=0x22, disp_valid=1 at that edge. Then busin=0x67, wa=1 -> display=0x67. disp_ack=1 -> disp_valid=0, display stays 0x67.
2. FIFO latency: mode=1, write 0x22 -> display=0x22, disp_valid=1 one edge later, count returns to 0.
3. FIFO fill/back-to-back: write 0x01..0x04 with disp_ack=0 -> count reaches 3 (head on display), then 4 after a 5th write 0x05, full=1. Hold disp_ack=1 -> display shows 0x02,0x03,0x04,0x05 on consecutive edges, then disp_valid=0 and empty=1.
4. Overflow: with full=1, write 0x99 -> dropped, overflow=1, 0x99 never displayed. With OUTREG_DROP_CNT_EN, drop_cnt=1; after 300 drops, drop_cnt=255.
5. Wrap-around plus simultaneous push/pop: stream 10 values with wa and disp_ack asserted together -> output order matches input order, count stays constant, pointers wrap correctly.
6. Reset and mode switch mid-stream: with 3 entries queued, toggle mode -> count=0, disp_valid=0, display held. Refill, then clr=0 -> all outputs at their reset values at that edge.
